// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//
// Decodes a 1-bit spike train back into rate-coded spike counts. Spikes are
// counted over back-to-back windows of programmable length. Each completed
// window count is queued in a small result FIFO. The FIFO drains through a
// valid/ready handshake.
//
// Optional build macro:
//   SPIKE_DEC_SYNC_EN - route spike_in through a 2-flop synchronizer (reset
//                       to 0) before counting. Use this when the spike source
//                       sits in another clock domain. It adds two cycles of
//                       latency.
//
// Parameters:
//   WIN_W      - width of window_len and of the cycle counter
//   CNT_W      - width of the spike count and of rate_data
//   FIFO_DEPTH - result FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - run decoding; low returns to idle and drops the partial window
//   spike_in   - spike sample, one per cycle
//   window_len - window length in cycles (0 is treated as 1), latched at
//                window start
//   rate_data  - spike count at the FIFO head (registered)
//   rate_valid - FIFO non-empty (registered)
//   rate_ready - consumer accepts the head this cycle
//   overflow   - sticky: a window result was dropped because the FIFO was full
//   clr_ovf    - synchronous clear of overflow (a simultaneous drop wins)
// ---------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int WIN_W      = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_data,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Increment by one spike, holding at the all-ones ceiling.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic             inc);
        logic [CNT_W-1:0] r;
        if (inc && (c != {CNT_W{1'b1}})) begin
            r = c + CNT_W'(1);
        end else begin
            r = c;
        end
        return r;
    endfunction

    // A zero-length window would never end, so treat it as one cycle.
    function automatic logic [WIN_W-1:0] eff_len(input logic [WIN_W-1:0] l);
        logic [WIN_W-1:0] r;
        if (l == {WIN_W{1'b0}}) begin
            r = WIN_W'(1);
        end else begin
            r = l;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Spike input conditioning
    // ------------------------------------------------------------------
    logic spike_s;

`ifdef SPIKE_DEC_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for a spike source in a foreign clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= spike_in;
            sync2_r <= sync1_r;
        end
    end

    assign spike_s = sync2_r;
`else
    assign spike_s = spike_in;
`endif

    // ------------------------------------------------------------------
    // Window counter FSM
    // ------------------------------------------------------------------
    state_t           state_r, state_nxt_s;
    logic [WIN_W-1:0] len_r, len_nxt_s;
    logic [WIN_W-1:0] cyc_r, cyc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIN_W-1:0] cur_len_s;
    logic [WIN_W-1:0] cur_cyc_s;
    logic [CNT_W-1:0] cur_cnt_s;
    logic [CNT_W-1:0] sum_s;
    logic             push_s;
    logic [CNT_W-1:0] push_data_s;

    // FSM state and window counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            len_r   <= {WIN_W{1'b0}};
            cyc_r   <= {WIN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            cyc_r   <= cyc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic. The idle->count edge already samples window cycle 0,
    // so it is handled as a counting edge with a freshly latched length.
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        cyc_nxt_s   = cyc_r;
        cnt_nxt_s   = cnt_r;
        cur_len_s   = len_r;
        cur_cyc_s   = cyc_r;
        cur_cnt_s   = cnt_r;
        sum_s       = {CNT_W{1'b0}};
        push_s      = 1'b0;
        push_data_s = {CNT_W{1'b0}};

        case (state_r)
            ST_IDLE: begin
                cur_len_s = eff_len(window_len);
                cur_cyc_s = {WIN_W{1'b0}};
                cur_cnt_s = {CNT_W{1'b0}};
            end
            ST_COUNT: begin
                cur_len_s = len_r;
                cur_cyc_s = cyc_r;
                cur_cnt_s = cnt_r;
            end
            default: begin
                cur_len_s = eff_len(window_len);
                cur_cyc_s = {WIN_W{1'b0}};
                cur_cnt_s = {CNT_W{1'b0}};
            end
        endcase

        if (!enable) begin
            // Deassertion beats a coincident window end: nothing is pushed.
            state_nxt_s = ST_IDLE;
            len_nxt_s   = {WIN_W{1'b0}};
            cyc_nxt_s   = {WIN_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            state_nxt_s = ST_COUNT;
            sum_s       = sat_add(cur_cnt_s, spike_s);
            if (cur_cyc_s == (cur_len_s - WIN_W'(1))) begin
                // Last window cycle: emit and roll straight into the next window.
                push_s      = 1'b1;
                push_data_s = sum_s;
                len_nxt_s   = eff_len(window_len);
                cyc_nxt_s   = {WIN_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
                len_nxt_s   = cur_len_s;
                cyc_nxt_s   = cur_cyc_s + WIN_W'(1);
                cnt_nxt_s   = sum_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO with registered head
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             rate_valid_r;
    logic [CNT_W-1:0] rate_data_r;
    logic             overflow_r;

    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             drop_s;
    logic [OCC_W-1:0] occ_after_pop_s;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] head_nxt_s;
    logic             ovf_nxt_s;

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        pop_s   = rate_valid_r & rate_ready;
        full_s  = (occ_r == OCC_W'(FIFO_DEPTH));
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;

        if (pop_s) begin
            occ_after_pop_s = occ_r - OCC_W'(1);
            rd_ptr_nxt_s    = rd_ptr_r + PTR_W'(1);
        end else begin
            occ_after_pop_s = occ_r;
            rd_ptr_nxt_s    = rd_ptr_r;
        end

        if (wr_en_s) begin
            occ_nxt_s = occ_after_pop_s + OCC_W'(1);
        end else begin
            occ_nxt_s = occ_after_pop_s;
        end

        // Writing into an otherwise empty FIFO: the new entry is the head.
        if (wr_en_s && (occ_after_pop_s == {OCC_W{1'b0}})) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow_r;
        end
    end

    // FIFO storage, pointers, registered head and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {CNT_W{1'b0}};
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            occ_r        <= {OCC_W{1'b0}};
            rate_valid_r <= 1'b0;
            rate_data_r  <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r     <= rd_ptr_nxt_s;
            occ_r        <= occ_nxt_s;
            rate_valid_r <= (occ_nxt_s != {OCC_W{1'b0}});
            if (occ_nxt_s != {OCC_W{1'b0}}) begin
                rate_data_r <= head_nxt_s;
            end else begin
                rate_data_r <= rate_data_r;
            end
            overflow_r   <= ovf_nxt_s;
        end
    end

    assign rate_data  = rate_data_r;
    assign rate_valid = rate_valid_r;
    assign overflow   = overflow_r;

endmodule
